// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with mid-bit sampling.
// rx_serial is synchronized (2 FFs) plus one edge register. A high-to-low
// transition of the synchronized line starts a frame. Each bit is sampled at
// its centre: half a bit after the start edge, then every full bit period.
// A good stop bit latches the byte and pulses data_valid for one cycle.
// A low stop bit pulses framing_error instead and leaves out_data untouched.
module uart_rx_sampler #(
  parameter int baudrate       = 115_200,
  parameter int base_clk       = 50_000_000,
  parameter int clocks_per_bit = base_clk / baudrate,
  parameter int half_bit       = clocks_per_bit / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] out_data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // The counter runs from 0 and is compared against "last count" values.
  // One bit therefore takes exactly clocks_per_bit cycles.
  localparam logic [31:0] BIT_LAST  = 32'(clocks_per_bit - 1);
  localparam logic [31:0] HALF_LAST = 32'(half_bit - 1);

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        start_edge;

  // Metastability guard plus previous-sample copy; the idle line level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Only a real falling transition starts a frame. A line held low does not.
  assign start_edge = prev_q & ~sync2_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: bit timing, mid-bit sampling and frame check.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // If the line is high again at mid start bit, the edge was a glitch.
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = sync2_q;
          // Leave bit_idx at 7 rather than letting it wrap to 0.
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            out_data_d = shift_q;
            valid_d    = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data      = out_data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler. Instance A uses the default 115200 baud
// from 50 MHz. Instance B runs at 5 Mbaud so that all 256 byte values can be
// looped through in a short run.
module tb_uart_rx_sampler;

  localparam int CPB_A  = 50_000_000 / 115_200;   // 434
  localparam int HALF_A = CPB_A / 2;              // 217
  localparam int LAT_A  = HALF_A + 9 * CPB_A;     // busy rise -> pulse: 4123
  localparam int CPB_B  = 10;
  localparam int HALF_B = CPB_B / 2;
  localparam int LAT_B  = HALF_B + 9 * CPB_B;

  typedef struct packed {
    logic       fe;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] od_a, od_b;
  logic       dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   pulses_a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_sampler u_a (
    .clk(clk), .rst(rst), .rx_serial(rx_a), .out_data(od_a),
    .data_valid(dv_a), .framing_error(fe_a), .busy(busy_a)
  );

  uart_rx_sampler #(.baudrate(5_000_000), .base_clk(50_000_000)) u_b (
    .clk(clk), .rst(rst), .rx_serial(rx_b), .out_data(od_b),
    .data_valid(dv_b), .framing_error(fe_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop);
    int cpb;
    cpb = sel ? CPB_B : CPB_A;
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
    drive(sel, stop, cpb);
  endtask

  // Monitor A: pulse legality, latency from busy rise, scoreboard compare.
  logic busy_a_prev = 1'b0, pulse_a_prev = 1'b0;
  int   rise_a = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_a && !busy_a_prev) rise_a = cyc;
      if (dv_a || fe_a) begin
        chk("pulse_excl_a", 32'(dv_a & fe_a), 32'd0);
        chk("pulse_width_a", 32'(pulse_a_prev), 32'd0);
        chk("pulse_lat_a", 32'(cyc - rise_a), 32'(LAT_A));
        pulses_a.push_back(cyc);
        if (exp_a.size() == 0) begin
          chk("unexp_pulse_a", 32'(exp_a.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_a.pop_front();
          chk("ferr_a", 32'(fe_a), 32'(e.fe));
          chk("valid_a", 32'(dv_a), 32'(!e.fe));
          chk("data_a", 32'(od_a), 32'(e.d));
        end
      end
    end
    busy_a_prev  = busy_a;
    pulse_a_prev = dv_a | fe_a;
  end

  // Monitor B: same scoring for the fast loopback instance.
  logic busy_b_prev = 1'b0, pulse_b_prev = 1'b0;
  int   rise_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_b && !busy_b_prev) rise_b = cyc;
      if (dv_b || fe_b) begin
        chk("pulse_width_b", 32'(pulse_b_prev), 32'd0);
        chk("pulse_lat_b", 32'(cyc - rise_b), 32'(LAT_B));
        if (exp_b.size() == 0) begin
          chk("unexp_pulse_b", 32'(exp_b.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_b.pop_front();
          chk("ferr_b", 32'(fe_b), 32'(e.fe));
          chk("valid_b", 32'(dv_b), 32'(!e.fe));
          chk("data_b", 32'(od_b), 32'(e.d));
        end
      end
    end
    busy_b_prev  = busy_b;
    pulse_b_prev = dv_b | fe_b;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n0;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(od_a), 32'h00);
    chk("rst_valid", 32'(dv_a), 32'd0);
    chk("rst_ferr", 32'(fe_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;

    // Good frame after a long idle.
    drive(0, 1'b1, 1000);
    exp_a.push_back('{fe: 1'b0, d: 8'hA5});
    send(0, 8'hA5, 1'b1);
    drive(0, 1'b1, 100);
    chk("good_data", 32'(od_a), 32'hA5);

    // Glitch: low for 100 cycles. busy should last exactly half_bit cycles.
    rx_a = 1'b0;
    hi = 0;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      if (t == 100) rx_a = 1'b1;
      if (busy_a) hi++;
    end
    chk("glitch_busy_len", 32'(hi), 32'(HALF_A));
    chk("glitch_busy_end", 32'(busy_a), 32'd0);
    chk("glitch_data", 32'(od_a), 32'hA5);

    // Framing error. The line then stays low, which must not start a frame.
    exp_a.push_back('{fe: 1'b0, d: 8'h11});
    send(0, 8'h11, 1'b1);
    drive(0, 1'b1, 200);
    exp_a.push_back('{fe: 1'b1, d: 8'h11});
    send(0, 8'h3C, 1'b0);
    drive(0, 1'b0, 2000);
    chk("ferr_no_restart", 32'(busy_a), 32'd0);
    chk("ferr_data_kept", 32'(od_a), 32'h11);
    drive(0, 1'b1, 1000);

    // Back-to-back frames with no idle gap.
    n0 = pulses_a.size();
    exp_a.push_back('{fe: 1'b0, d: 8'h00});
    exp_a.push_back('{fe: 1'b0, d: 8'hFF});
    exp_a.push_back('{fe: 1'b0, d: 8'h5A});
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'h5A, 1'b1);
    drive(0, 1'b1, 500);
    chk("b2b_count", 32'(pulses_a.size() - n0), 32'd3);
    if (pulses_a.size() >= n0 + 3) begin
      chk("b2b_gap0", 32'(pulses_a[n0+1] - pulses_a[n0]), 32'd4340);
      chk("b2b_gap1", 32'(pulses_a[n0+2] - pulses_a[n0+1]), 32'd4340);
    end
    chk("b2b_last", 32'(od_a), 32'h5A);

    // Reset in the middle of data bit 4 of 0xC3. The sender aborts as well.
    drive(0, 1'b0, CPB_A);
    for (int i = 0; i < 4; i++) drive(0, 1'(8'hC3 >> i), CPB_A);
    drive(0, 1'b0, 200);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1; rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_data", 32'(od_a), 32'h00);
    chk("mid_rst_pulse", 32'(dv_a | fe_a), 32'd0);
    drive(0, 1'b1, 1000);
    exp_a.push_back('{fe: 1'b0, d: 8'h7E});
    send(0, 8'h7E, 1'b1);
    drive(0, 1'b1, 200);
    chk("post_rst_data", 32'(od_a), 32'h7E);

    // Loopback of all byte values on the fast instance.
    for (int b = 0; b < 256; b++) begin
      exp_b.push_back('{fe: 1'b0, d: 8'(b)});
      send(1, 8'(b), 1'b1);
    end
    drive(1, 1'b1, 50);

    for (int k = 0; k < 10000 && (exp_a.size() != 0 || exp_b.size() != 0); k++)
      @(negedge clk);
    chk("sb_drain_a", 32'(exp_a.size()), 32'd0);
    chk("sb_drain_b", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
